commit_trace_buffer: RTL and testbench

//   Receiving end of the writeback debug-commit interface. Captures per-cycle commit records
//   (pc, wen, wnum, wdata) from both writeback pipes, buffers them in program order
//   (pipe0 before pipe1 within a cycle) in a FIFO, and drains them one per handshake
//   to a trace consumer: difftest shim, golden-trace comparator or trace DMA.

---
 rtl/commit_trace_buffer.sv | 103 ++++++++++
 tb/tb_commit_trace_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: collects dual-pipe writeback commit records in program order
// and presents them first-word-fall-through to a trace consumer with a ready/valid handshake.
module commit_trace_buffer #(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit0_i,
  input  logic [31:0]      pc0_i,
  input  logic [3:0]       wen0_i,
  input  logic [4:0]       wnum0_i,
  input  logic [31:0]      wdata0_i,
  input  logic             commit1_i,
  input  logic [31:0]      pc1_i,
  input  logic [3:0]       wen1_i,
  input  logic [4:0]       wnum1_i,
  input  logic [31:0]      wdata1_i,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [31:0]      trace_pc_o,
  output logic [3:0]       trace_wen_o,
  output logic [4:0]       trace_wnum_o,
  output logic [31:0]      trace_wdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  input  logic             clear_overflow_i
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  rec_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  rec_t             w_rec0;
  rec_t             w_rec1;
  rec_t             w_head;
  logic             w_pop;
  logic [CNT_W-1:0] w_free;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_drop;
  logic [1:0]       w_n_acc;
  logic [PTR_W-1:0] w_wr_ptr1;

  assign w_rec0 = {pc0_i, wen0_i, wnum0_i, wdata0_i};
  assign w_rec1 = {pc1_i, wen1_i, wnum1_i, wdata1_i};

  assign trace_valid_o = (r_count != '0);
  assign w_pop         = trace_valid_o & trace_ready_i;

  // A pop in this cycle frees its slot for a same-cycle push.
  assign w_free = CNT_W'(DEPTH) - r_count + CNT_W'(w_pop);

  // Records are accepted strictly in order: pipe1 only gets a slot left over after pipe0.
  always_comb begin
    w_acc0    = commit0_i && (w_free != '0);
    w_acc1    = commit1_i && (w_free > CNT_W'(w_acc0));
    w_drop    = (commit0_i && !w_acc0) || (commit1_i && !w_acc1);
    w_n_acc   = {1'b0, w_acc0} + {1'b0, w_acc1};
    w_wr_ptr1 = r_wr_ptr + PTR_W'(w_acc0);
  end

  // NOTE: storage has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_acc0) r_mem[r_wr_ptr]  <= w_rec0;
    if (w_acc1) r_mem[w_wr_ptr1] <= w_rec1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + PTR_W'(w_n_acc);
      r_rd_ptr   <= r_rd_ptr + PTR_W'(w_pop);
      r_count    <= r_count + CNT_W'(w_n_acc) - CNT_W'(w_pop);
      r_overflow <= w_drop | (r_overflow & ~clear_overflow_i);
    end
  end

  assign w_head        = trace_valid_o ? r_mem[r_rd_ptr] : '0;
  assign trace_pc_o    = w_head.pc;
  assign trace_wen_o   = w_head.wen;
  assign trace_wnum_o  = w_head.wnum;
  assign trace_wdata_o = w_head.wdata;
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: a DEPTH=16 and a DEPTH=4 instance share stimulus;
// sel chooses which one the monitor and direct checks observe.
module tb_commit_trace_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic commit0 = 1'b0, commit1 = 1'b0;
  rec_t r0 = '0, r1 = '0;
  logic ready = 1'b0, clr = 1'b0;
  logic sel = 1'b0;

  logic        v16, v4, ovf16, ovf4;
  logic [31:0] pc16, pc4, wd16, wd4;
  logic [3:0]  wen16, wen4;
  logic [4:0]  wn16, wn4, cnt16;
  logic [2:0]  cnt4;

  logic        act_valid, act_ovf;
  rec_t        act_rec;
  logic [4:0]  act_count;

  rec_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .commit0_i(commit0), .pc0_i(r0.pc), .wen0_i(r0.wen), .wnum0_i(r0.wnum), .wdata0_i(r0.wdata),
    .commit1_i(commit1), .pc1_i(r1.pc), .wen1_i(r1.wen), .wnum1_i(r1.wnum), .wdata1_i(r1.wdata),
    .trace_valid_o(v16), .trace_ready_i(ready), .trace_pc_o(pc16), .trace_wen_o(wen16),
    .trace_wnum_o(wn16), .trace_wdata_o(wd16), .count_o(cnt16), .overflow_o(ovf16),
    .clear_overflow_i(clr)
  );

  commit_trace_buffer #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .commit0_i(commit0), .pc0_i(r0.pc), .wen0_i(r0.wen), .wnum0_i(r0.wnum), .wdata0_i(r0.wdata),
    .commit1_i(commit1), .pc1_i(r1.pc), .wen1_i(r1.wen), .wnum1_i(r1.wnum), .wdata1_i(r1.wdata),
    .trace_valid_o(v4), .trace_ready_i(ready), .trace_pc_o(pc4), .trace_wen_o(wen4),
    .trace_wnum_o(wn4), .trace_wdata_o(wd4), .count_o(cnt4), .overflow_o(ovf4),
    .clear_overflow_i(clr)
  );

  assign act_valid = sel ? v4 : v16;
  assign act_ovf   = sel ? ovf4 : ovf16;
  assign act_count = sel ? {2'b00, cnt4} : cnt16;
  assign act_rec   = sel ? {pc4, wen4, wn4, wd4} : {pc16, wen16, wn16, wd16};

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic rec_t mk(input logic [31:0] pc);
    rec_t r;
    r.pc    = pc;
    r.wen   = pc[5:2];
    r.wnum  = pc[6:2];
    r.wdata = ~pc;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one commit cycle; k0/k1 say whether each record is expected to be kept.
  task automatic commit(input logic c0, input rec_t a, input logic k0,
                        input logic c1, input rec_t b, input logic k1);
    commit0 = c0; r0 = a;
    commit1 = c1; r1 = b;
    if (c0 && k0) q.push_back(a);
    if (c1 && k1) q.push_back(b);
    cyc();
    commit0 = 1'b0; commit1 = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    cyc();
  endtask

  // Monitor: every handshake on the observed instance must match the scoreboard head.
  always @(negedge clk) begin
    if (rst && act_valid && ready) begin
      if (q.size() == 0) begin
        check("unexpected_record", act_rec, '0);
      end else begin
        rec_t e;
        e = q.pop_front();
        check("head_record", act_rec, e);
      end
    end
  end

  initial begin
    int m_count;
    int issued;
    logic c;
    logic p;

    // Reset state
    #2;
    check("reset_valid", act_valid, 0);
    check("reset_count", act_count, 0);
    check("reset_ovf", act_ovf, 0);
    reset_pulse();

    // Single commit, popped immediately
    ready = 1'b1;
    commit(1, '{pc:32'hBFC00000, wen:4'hF, wnum:5'd3, wdata:32'h00001234}, 1, 0, '0, 0);
    check("t2_valid", act_valid, 1);
    check("t2_count", act_count, 1);
    check("t2_pc", act_rec.pc, 32'hBFC00000);
    cyc();
    check("t2_count_after_pop", act_count, 0);
    check("t2_valid_after_pop", act_valid, 0);
    check("t2_data_zero", act_rec, '0);

    // Dual commit ordering, then pipe1-only commit
    ready = 1'b0;
    commit(1, mk(32'h100), 1, 1, mk(32'h104), 1);
    check("t3_count", act_count, 2);
    check("t3_head0", act_rec.pc, 32'h100);
    ready = 1'b1;
    cyc();
    check("t3_head1", act_rec.pc, 32'h104);
    cyc();
    ready = 1'b0;
    commit(0, '0, 0, 1, mk(32'h108), 1);
    check("t3_p1_count", act_count, 1);
    check("t3_p1_head", act_rec.pc, 32'h108);
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    check("t3_empty", act_count, 0);

    // Async reset mid-stream with five records held
    commit(1, mk(32'h110), 1, 1, mk(32'h114), 1);
    commit(1, mk(32'h118), 1, 1, mk(32'h11C), 1);
    commit(1, mk(32'h120), 1, 0, '0, 0);
    check("t1_count5", act_count, 5);
    #2 rst = 1'b0;
    #1;
    check("t1_rst_valid", act_valid, 0);
    check("t1_rst_count", act_count, 0);
    check("t1_rst_ovf", act_ovf, 0);
    check("t1_rst_data", act_rec, '0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    commit(1, mk(32'h124), 1, 0, '0, 0);
    check("t1_fresh_count", act_count, 1);
    check("t1_fresh_head", act_rec.pc, 32'h124);
    ready = 1'b1;
    cyc();
    ready = 1'b0;

    // Switch observation to the DEPTH=4 instance
    sel = 1'b1;
    reset_pulse();

    // Overflow with partial acceptance
    commit(1, mk(32'h1F0), 1, 1, mk(32'h1F4), 1);
    commit(1, mk(32'h1F8), 1, 0, '0, 0);
    check("t4_count3", act_count, 3);
    check("t4_ovf_pre", act_ovf, 0);
    commit(1, mk(32'h200), 1, 1, mk(32'h204), 0);
    check("t4_count_full", act_count, 4);
    check("t4_ovf_set", act_ovf, 1);
    clr = 1'b1;
    commit(1, mk(32'h208), 0, 0, '0, 0);
    check("t4_clear_vs_drop", act_ovf, 1);
    check("t4_count_still_full", act_count, 4);
    cyc();
    clr = 1'b0;
    check("t4_cleared", act_ovf, 0);

    // Full with same-cycle pop
    ready = 1'b1;
    commit(1, mk(32'h300), 1, 0, '0, 0);
    check("t5_count", act_count, 4);
    check("t5_no_ovf", act_ovf, 0);
    commit(1, mk(32'h304), 1, 1, mk(32'h308), 0);
    check("t5_dual_count", act_count, 4);
    check("t5_dual_ovf", act_ovf, 1);
    clr = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    clr = 1'b0;
    ready = 1'b0;
    check("t5_drained", act_count, 0);
    check("t5_ovf_cleared", act_ovf, 0);

    // Wrap-around: 40 single commits, random ready, never exceeding capacity
    m_count = 0;
    issued  = 0;
    for (int i = 0; i < 400 && issued < 40; i++) begin
      ready = 1'($urandom_range(0, 1));
      c = (m_count < 4);
      p = ready && (m_count != 0);
      commit(c, mk(32'(issued * 4)), 1, 0, '0, 0);
      if (c) issued++;
      m_count = m_count + int'(c) - int'(p);
      check("t6_count", act_count, 73'(m_count));
    end
    check("t6_all_issued", 73'(issued), 73'd40);
    ready = 1'b1;
    for (int i = 0; i < 8 && m_count > 0; i++) begin
      cyc();
      m_count--;
    end
    ready = 1'b0;
    check("t6_drained", act_count, 0);
    check("t6_no_ovf", act_ovf, 0);
    check("scoreboard_empty", 73'(q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
